alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Generalised data width; adds a valid/ready handshake on both sides, registered result and flags, a carry/zero flag set, and barrel shifts.
- Adds an iterative multi-cycle multiplier.
- Sits between the register-file read stage and writeback; the control unit issues one operation at a time and stalls on in_ready.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- SHW, $clog2(WIDTH), shift-amount width, derived; not user-set.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op1/op2/aluop valid this cycle
- in_ready  out  1  block can accept a new operation
- aluop  in  4  operation select
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- equal  out  1  op1 == op2 (EQ, SLTE only; else 0)
- less_than  out  1  unsigned compare (SLT, SLTE only; else 0)
- carry  out  1  carry-out (ADD) / borrow (SUB); else 0
- zero  out  1  result == 0, for every legal op
- illegal  out  1  aluop not defined; result 0

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR
  - 3 ADD: result = low WIDTH bits, carry = bit WIDTH
  - 4 SUB: carry = 1 when op1 < op2
  - 5 SLT
  - 6 SLTE: sets less_than (op1 <= op2) and equal
  - 7 EQ
  - 8 SHL and 9 SHR: logical, amount = op2[SHW-1:0]; bits above are ignored
  - 10 MUL: low WIDTH bits of op1*op2, unsigned
  - 11-15: illegal
- Compare ops (5-7): result = 0 and zero = 1.
- Illegal ops: result 0, zero 0, illegal 1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, operands and aluop are captured.
  - Non-MUL ops compute into the output registers and go to DONE, so out_valid rises in the next cycle (latency 1).
  - MUL goes to BUSY.
- BUSY:
  - Shift-add, one multiplier bit per cycle; a counter runs WIDTH-1 down to 0.
  - in_ready = 0 and out_valid = 0.
  - When the counter reaches 0, go to DONE. out_valid is first high WIDTH+1 cycles after the accept edge.
- DONE:
  - out_valid = 1; result and flags held stable until out_ready.
  - in_ready = out_ready, which allows back-to-back issue.
  - out_ready with no in_valid: go to IDLE.
  - out_ready and in_valid in the same cycle: the result is consumed and the new op is captured in that cycle; next state follows the IDLE rules.
- Inputs are ignored whenever in_ready = 0. Operand changes while BUSY have no effect.
- Reset (async, any state, including mid-MUL):
  - State goes to IDLE.
  - out_valid, result, equal, less_than, carry, zero, illegal and the MUL counter all go to 0.
  - in_ready = 1 after release.
  - A partial product is discarded and never emitted.
- Outputs are driven only from registers; there is no combinational path from op1/op2 to result.

Optional Feature:
- ALU_MUL_EN: defined means opcode 10 behaves as above.
- Undefined means:
  - The multiplier datapath, counter and BUSY state are not built.
  - Opcode 10 is treated as illegal, with latency 1.
  - in_ready is never low in IDLE.

Test Plan:
- WIDTH=8, ADD op1=0xF0 op2=0x20 -> one cycle later out_valid=1, result=0x10, carry=1, zero=0.
- SUB 0x05-0x05 -> result 0x00, zero=1, carry=0. SUB 0x03-0x07 -> result 0xFC, carry=1.
- SLTE 3,3 -> less_than=1, equal=1, result 0. SLT 3,3 -> less_than=0, equal=0. SHL 0x81 by op2=0x09 -> amount 1, result 0x02. SHR 0x80 by 7 -> result 0x01.
- MUL (ALU_MUL_EN) 13*11 -> in_ready=0 for 8 cycles, out_valid exactly 9 cycles after accept, result 0x8F. 0xFF*0xFF -> 0x01. Without the macro, MUL -> illegal=1, result 0, latency 1.
- Backpressure: ADD accepted, out_ready held 0 for 3 cycles -> result, flags and out_valid stable, in_ready=0. Then out_ready=1 with a new in_valid XOR 0xAA^0x0F -> next cycle result 0x0F... 0xA5, with no gap cycle.
- Reset mid-MUL: assert rst_n=0 on the 4th BUSY cycle -> all outputs 0 immediately and in_ready=1 after release. A subsequent ADD 1+1 -> result 0x02, with no stale product emitted. aluop=0xC -> illegal=1, result 0.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
//
// Takes one operation at a time. Single-cycle ops (logic, add/sub,
// compares, barrel shifts) produce a result one cycle after they are
// accepted. The optional multiplier uses shift-add, one multiplier bit per
// cycle, so its result appears WIDTH+1 cycles after the issue cycle.
// The result and its flags are held until the consumer takes them. A new
// operation can be accepted in the same cycle the old result is consumed.
//
// Build option:
//   ALU_MUL_EN  defined   : opcode 10 (MUL) uses the iterative multiplier.
//               undefined : no multiplier, counter or BUSY state is built;
//                           opcode 10 is reported as illegal with latency 1.
//
// Parameters:
//   WIDTH      operand/result width (>= 2); SHW = $clog2(WIDTH) is derived
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   aluop/op1/op2 valid this cycle
//   in_ready   block can accept an operation this cycle
//   aluop      operation select (0..10 legal, 11..15 illegal)
//   op1, op2   operands
//   out_valid  result and flags valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   equal      op1 == op2 (EQ, SLTE)
//   less_than  unsigned op1 < op2 (SLT) or op1 <= op2 (SLTE)
//   carry      carry-out (ADD) or borrow (SUB)
//   zero       result == 0 for every legal op
//   illegal    aluop is not a defined operation
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             less_than,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTE = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             eq;
    logic             lt;
    logic             cy;
    logic             zf;
    logic             ill;
  } alu_out_t;

  // Single-cycle operation table. Compare ops leave res at 0, so zero is
  // naturally 1 for them; illegal ops force zero low.
  function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t     o;
    logic [WIDTH:0] wide;
    o    = '0;
    wide = '0;
    case (op)
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_XOR:  o.res = a ^ b;
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        o.res = wide[WIDTH-1:0];
        o.cy  = wide[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        wide  = {1'b0, a} - {1'b0, b};
        o.res = wide[WIDTH-1:0];
        o.cy  = wide[WIDTH];
      end
      OP_SLT:  o.lt = (a < b);
      OP_SLTE: begin
        o.lt = (a <= b);
        o.eq = (a == b);
      end
      OP_EQ:   o.eq = (a == b);
      OP_SHL:  o.res = a << b[SHW-1:0];
      OP_SHR:  o.res = a >> b[SHW-1:0];
      default: o.ill = 1'b1;
    endcase
    o.zf = !o.ill && (o.res == '0);
    return o;
  endfunction

  state_t   state_q;
  state_t   state_d;
  logic     accept;
  logic     is_mul;
  alu_out_t ev;

`ifdef ALU_MUL_EN
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0] mplier_p0;
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;

  assign is_mul   = (aluop == OP_MUL);
  assign acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign mul_last = (state_q == BUSY) && (cnt_q == '0);
`else
  assign is_mul = 1'b0;
`endif

  always_comb ev = alu_eval(aluop, op1, op2);

  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A consumed result in DONE makes the block behave as IDLE in the same
  // cycle, so a waiting operation is accepted without a bubble.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
`ifdef ALU_MUL_EN
      BUSY: if (cnt_q == '0) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
`ifdef ALU_MUL_EN
      state_d = is_mul ? BUSY : DONE;
`else
      state_d = DONE;
`endif
    end
  end

`ifdef ALU_MUL_EN
  // ---- stage p0: multiplier iteration (operands captured on accept) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && is_mul) begin
      cnt_q <= SHW'(WIDTH - 1);
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SHW'(1);
    end
  end

  // The accumulator is cleared on every accept, so a product interrupted
  // by reset can never leak into a later result.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_p0  <= op1;
      mplier_p0 <= op2;
      acc_p0    <= '0;
    end else if (state_q == BUSY) begin
      acc_p0    <= acc_next;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end
`endif

  // ---- output registers: result and flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      equal     <= 1'b0;
      less_than <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= ev.res;
      equal     <= ev.eq;
      less_than <= ev.lt;
      carry     <= ev.cy;
      zero      <= ev.zf;
      illegal   <= ev.ill;
    end
`ifdef ALU_MUL_EN
    else if (mul_last) begin
      result    <= acc_next;
      equal     <= 1'b0;
      less_than <= 1'b0;
      carry     <= 1'b0;
      zero      <= (acc_next == '0);
      illegal   <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTE = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   aluop = 4'd0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         equal;
  logic         less_than;
  logic         carry;
  logic         zero;
  logic         illegal;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .equal     (equal),
    .less_than (less_than),
    .carry     (carry),
    .zero      (zero),
    .illegal   (illegal)
  );

  // Expected flags packed as {eq, lt, cy, zf, ill}.
  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic [4:0] f);
    exp_t e;
    e.res   = r;
    e.flags = f;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the edge after a cycle with
  // out_valid && out_ready, so compare it mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h with no expected entry", result);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_result", 32'(result), 32'(mon_e.res));
        check("sb_flags", 32'({equal, less_than, carry, zero, illegal}), 32'(mon_e.flags));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
    int n;
    aluop    = op;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("issue_timeout_in_ready", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_result"}, 32'(result), 32'(0));
    check({tag, "_flags"}, 32'({equal, less_than, carry, zero, illegal}), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Latency-1 ADD with carry out
    check("add_pre_valid", 32'(out_valid), 32'(0));
    issue(OP_ADD, 8'hF0, 8'h20, mk(8'h10, 5'b00100));
    check("add_latency_valid", 32'(out_valid), 32'(1));

    // Back-to-back single-cycle ops
    issue(OP_SUB,  8'h05, 8'h05, mk(8'h00, 5'b00010));
    issue(OP_SUB,  8'h03, 8'h07, mk(8'hFC, 5'b00100));
    issue(OP_SLTE, 8'h03, 8'h03, mk(8'h00, 5'b11010));
    issue(OP_SLT,  8'h03, 8'h03, mk(8'h00, 5'b00010));
    issue(OP_SLT,  8'h02, 8'h09, mk(8'h00, 5'b01010));
    issue(OP_SLTE, 8'h05, 8'h03, mk(8'h00, 5'b00010));
    issue(OP_SHL,  8'h81, 8'h09, mk(8'h02, 5'b00000));
    issue(OP_SHR,  8'h80, 8'h07, mk(8'h01, 5'b00000));
    issue(OP_AND,  8'hF0, 8'h3C, mk(8'h30, 5'b00000));
    issue(OP_OR,   8'hF0, 8'h0F, mk(8'hFF, 5'b00000));
    issue(OP_XOR,  8'hAA, 8'hAA, mk(8'h00, 5'b00010));
    issue(OP_EQ,   8'h05, 8'h06, mk(8'h00, 5'b00010));
    issue(OP_EQ,   8'h06, 8'h06, mk(8'h00, 5'b10010));
    issue(OP_ADD,  8'hFF, 8'h01, mk(8'h00, 5'b00110));
    issue(4'hC,    8'h12, 8'h34, mk(8'h00, 5'b00001));
    issue(4'hF,    8'h00, 8'h00, mk(8'h00, 5'b00001));
    drain();

`ifdef ALU_MUL_EN
    // Multiplier: busy for W cycles, result W+1 cycles after issue
    issue(OP_MUL, 8'd13, 8'd11, mk(8'h8F, 5'b00000));
    op1   = 8'h00;
    op2   = 8'h00;
    aluop = OP_XOR;
    for (int k = 0; k < W; k++) begin
      check("mul_busy_in_ready", 32'(in_ready), 32'(0));
      check("mul_busy_out_valid", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
    end
    check("mul_latency_valid", 32'(out_valid), 32'(1));
    issue(OP_MUL, 8'hFF, 8'hFF, mk(8'h01, 5'b00000));
    issue(OP_MUL, 8'h00, 8'h37, mk(8'h00, 5'b00010));
`else
    // Without the multiplier, MUL is an illegal op with latency 1
    issue(OP_MUL, 8'd13, 8'd11, mk(8'h00, 5'b00001));
    check("mul_illegal_latency_valid", 32'(out_valid), 32'(1));
`endif
    drain();

    // Backpressure: result held stable, then back-to-back issue
    out_ready = 1'b0;
    issue(OP_ADD, 8'h12, 8'h34, mk(8'h46, 5'b00000));
    check("bp_valid_rise", 32'(out_valid), 32'(1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_result", 32'(result), 32'(8'h46));
      check("bp_flags", 32'({equal, less_than, carry, zero, illegal}), 32'(0));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    issue(OP_XOR, 8'hAA, 8'h0F, mk(8'hA5, 5'b00000));
    check("b2b_out_valid", 32'(out_valid), 32'(1));
    check("b2b_result", 32'(result), 32'(8'hA5));
    drain();

    // Reset while an operation is in flight
`ifdef ALU_MUL_EN
    issue(OP_MUL, 8'h07, 8'h09, mk(8'h3F, 5'b00000));
    op1 = 8'hFF;
    op2 = 8'hFF;
    repeat (3) @(posedge clk);
    #3;
`else
    out_ready = 1'b0;
    issue(OP_ADD, 8'h40, 8'h41, mk(8'h81, 5'b00000));
    repeat (3) @(posedge clk);
    #3;
`endif
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("midreset_release_in_ready", 32'(in_ready), 32'(1));
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk);
      #1;
      check("midreset_no_stale_valid", 32'(out_valid), 32'(0));
    end

    issue(OP_ADD, 8'h01, 8'h01, mk(8'h02, 5'b00000));
    issue(4'hC,   8'h55, 8'h66, mk(8'h00, 5'b00001));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
